// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage to multi-cycle data memory sequencer; define DMEM_RANGE_CHECK_EN to add addr_fault range checking
module dmem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEMread,
  input  logic              MEMwrite,
  input  logic [31:0]       address,
  input  logic [31:0]       data,
  output logic [31:0]       MEM_result,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic              addr_fault
`endif
);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic en_n, we_n, req, bad;
  logic [ADDR_W-1:0] addr_n, idx;
  logic [31:0] wdata_n, res_n;
  assign req = MEMread | MEMwrite;
  assign idx = ADDR_W'((address - BASE_ADDR) >> 2);
  assign ready = (state == IDLE) ? ~req : (state == DONE);
`ifdef DMEM_RANGE_CHECK_EN
  logic fault_n;
  assign bad = (address < BASE_ADDR) ||
               ({1'b0, address} >= ({1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS))) ||
               (address[1:0] != 2'b00);
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    en_n = mem_en;
    we_n = mem_we;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    res_n = MEM_result;
`ifdef DMEM_RANGE_CHECK_EN
    fault_n = 1'b0;
`endif
    case (state)
      IDLE: if (req) begin
        state_n = bad ? DONE : BUSY;
        cnt_n = CNT_W'(WAIT_CYCLES - 1);
        en_n = ~bad;
        we_n = ~bad & ~MEMread;
        addr_n = idx;
        wdata_n = data;
        res_n = (bad & MEMread) ? '0 : MEM_result;
`ifdef DMEM_RANGE_CHECK_EN
        fault_n = bad;
`endif
      end
      BUSY: begin
        cnt_n = (cnt == '0) ? cnt : cnt - CNT_W'(1);
        if (cnt == '0) begin
          state_n = DONE;
          en_n = 1'b0;
          we_n = 1'b0;
          res_n = mem_we ? MEM_result : mem_rdata;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      MEM_result <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mem_en <= en_n;
      mem_we <= we_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      MEM_result <= res_n;
    end
  end
`ifdef DMEM_RANGE_CHECK_EN
  always_ff @(posedge clk) addr_fault <= rst ? 1'b0 : fault_n;
`endif
endmodule
